// File: rtl/display_frame_streamer_if.sv
// display_frame_streamer_if: frame capture handshake and marked beat stream of the frame streamer
interface display_frame_streamer_if #(
  parameter int WIDTH = 120,
  parameter int HEIGHT = 52,
  parameter int BEAT_W = 8
);
  logic frame_valid;
  logic frame_ready;
  logic [WIDTH*HEIGHT-1:0] frame_pix;
  logic out_valid;
  logic out_ready;
  logic [BEAT_W-1:0] out_data;
  logic out_sof;
  logic out_eof;
  logic out_sol;
  logic out_eol;
  logic [15:0] frame_count;
  modport master (
    input frame_valid, frame_pix, out_ready,
    output frame_ready, out_valid, out_data, out_sof, out_eof, out_sol, out_eol, frame_count
  );
  modport slave (
    output frame_valid, frame_pix, out_ready,
    input frame_ready, out_valid, out_data, out_sof, out_eof, out_sol, out_eol, frame_count
  );
endinterface

// File: rtl/display_frame_streamer.sv
// display_frame_streamer: captures a frame bitmap and streams it row-major as marked beats
module display_frame_streamer #(
  parameter int WIDTH = 120,
  parameter int HEIGHT = 52,
  parameter int BEAT_W = 8
) (
  input logic clk,
  input logic rst_n,
  display_frame_streamer_if.master bus
);
  localparam int N = WIDTH * HEIGHT;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  if (WIDTH % BEAT_W != 0) begin : g_bad_beat
    $error("WIDTH must be a multiple of BEAT_W");
  end
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q;
  logic [XW-1:0] x0_q;
  logic [YW-1:0] y_q;
  logic [N-1:0] buf_q;
  logic [15:0] count_q;
  logic [IW-1:0] base;
  logic stream, sol, eol, sof, eof, accept, load;
  always_comb begin
    stream = state_q == STREAM;
    sol = x0_q == '0;
    eol = x0_q == XW'(WIDTH - BEAT_W);
    sof = sol && y_q == '0;
    eof = eol && y_q == YW'(HEIGHT - 1);
    accept = stream && bus.out_ready;
    base = IW'(32'(WIDTH) * 32'(y_q) + 32'(x0_q));
  end
  // frame_ready follows out_ready on the eof beat so the next frame starts with no bubble
  assign bus.frame_ready = !stream || (eof && bus.out_ready);
  assign load = bus.frame_ready && bus.frame_valid;
  assign bus.out_valid = stream;
  assign bus.out_data = stream ? buf_q[base +: BEAT_W] : '0;
  assign bus.out_sof = stream && sof;
  assign bus.out_eof = stream && eof;
  assign bus.out_sol = stream && sol;
  assign bus.out_eol = stream && eol;
  assign bus.frame_count = count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x0_q <= '0;
      y_q <= '0;
      buf_q <= '0;
      count_q <= '0;
    end else begin
      if (accept && eof) count_q <= count_q + 16'd1;
      if (load) begin
        buf_q <= bus.frame_pix;
        x0_q <= '0;
        y_q <= '0;
        state_q <= STREAM;
      end else if (accept) begin
        x0_q <= eol ? '0 : x0_q + XW'(BEAT_W);
        y_q <= eof ? '0 : eol ? y_q + YW'(1) : y_q;
        state_q <= eof ? IDLE : STREAM;
      end
    end
  end
endmodule

// File: tb/tb_display_frame_streamer.sv
// tb_display_frame_streamer: randomized checks of the frame streamer against a beat-list model
module tb_display_frame_streamer;
  localparam int W = 8, H = 2, B = 4, NB = W * H / B;
  typedef struct packed {
    logic [B-1:0] d;
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } beat_t;
  logic clk = 0;
  logic rst_n = 0;
  int errs = 0, checks = 0, frames = 0;
  int cyc, stalls, stall_bad, pulses;
  beat_t exp_q[$], got_q[$];
  always #5 clk = ~clk;
  display_frame_streamer_if #(.WIDTH(W), .HEIGHT(H), .BEAT_W(B)) bus ();
  display_frame_streamer_if #(.WIDTH(8), .HEIGHT(1), .BEAT_W(8)) bus1 ();
  display_frame_streamer #(.WIDTH(W), .HEIGHT(H), .BEAT_W(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  display_frame_streamer #(.WIDTH(8), .HEIGHT(1), .BEAT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic beat_t cur();
    return {bus.out_data, bus.out_sof, bus.out_eof, bus.out_sol, bus.out_eol};
  endfunction

  // expected beats: row-major walk of the bitmap, B pixels per beat
  function automatic void model(input logic [W*H-1:0] f);
    beat_t b;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x += B) begin
        b.d = f[y*W+x +: B];
        b.sof = x == 0 && y == 0;
        b.eof = x == W - B && y == H - 1;
        b.sol = x == 0;
        b.eol = x == W - B;
        exp_q.push_back(b);
      end
  endfunction

  task automatic start(input logic [W*H-1:0] f);
    bus.frame_pix = f;
    bus.frame_valid = 1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready high; mode 1: 1,0,0,1 then random. frame_valid drops once drop beats seen.
  task automatic collect(input int n, input int mode, input int drop);
    beat_t held;
    bit was_stall;
    held = '0;
    was_stall = 0;
    cyc = 0;
    stalls = 0;
    stall_bad = 0;
    pulses = 0;
    got_q.delete();
    while (got_q.size() < n && cyc < 200) begin
      bus.out_ready = mode == 0 ? 1'b1 : (cyc == 1 || cyc == 2) ? 1'b0 :
                      (cyc == 0 || cyc == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (was_stall && cur() !== held) stall_bad++;
      was_stall = bus.out_valid && !bus.out_ready;
      held = cur();
      if (was_stall) stalls++;
      if (bus.out_valid && bus.frame_ready) pulses++;
      if (bus.out_valid && bus.out_ready) got_q.push_back(cur());
      if (got_q.size() >= drop) bus.frame_valid = 0;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.frame_valid = 0;
    bus.frame_pix = '0;
    bus.out_ready = 1;
    bus1.frame_valid = 0;
    bus1.frame_pix = '0;
    bus1.out_ready = 1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.frame_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", bus.frame_ready); end
    checks++; if (bus.frame_count !== 16'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", bus.frame_count); end
    checks++; if ({bus.out_sof, bus.out_eof, bus.out_sol, bus.out_eol} !== 4'b0) begin errs++; $display("FAIL reset_markers got=%b exp=0000", {bus.out_sof, bus.out_eof, bus.out_sol, bus.out_eol}); end
    checks++; if (bus.out_data !== '0) begin errs++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_single();
    logic [B-1:0] tbl [NB];
    tbl = '{4'hC, 4'h3, 4'h5, 4'hA};
    exp_q.delete();
    model(16'hA53C);
    start(16'hA53C);
    collect(NB, 0, 0);
    frames++;
    checks++; if (got_q.size() != NB) begin errs++; $display("FAIL single_beats got=%0d exp=%0d", got_q.size(), NB); end
    for (int i = 0; i < NB && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL single_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      checks++; if (got_q[i].d !== tbl[i]) begin errs++; $display("FAIL single_data%0d got=%h exp=%h", i, got_q[i].d, tbl[i]); end
    end
    checks++; if (cyc != NB) begin errs++; $display("FAIL single_cycles got=%0d exp=%0d", cyc, NB); end
    checks++; if (pulses != 1) begin errs++; $display("FAIL single_ready_pulses got=%0d exp=1", pulses); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.frame_ready !== 1'b1) begin errs++; $display("FAIL single_idle got=%b%b exp=01", bus.out_valid, bus.frame_ready); end
    checks++; if (bus.frame_count !== 16'(frames)) begin errs++; $display("FAIL single_count got=%0d exp=%0d", bus.frame_count, frames); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [W*H-1:0] f;
    for (int k = 0; k < 5; k++) begin
      f = k == 0 ? 16'hA53C : 16'($urandom);
      exp_q.delete();
      model(f);
      start(f);
      collect(NB, 1, 0);
      frames++;
      checks++; if (got_q.size() != NB) begin errs++; $display("FAIL bp_beats%0d got=%0d exp=%0d", k, got_q.size(), NB); end
      for (int i = 0; i < NB && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL bp_beat%0d_%0d got=%h exp=%h", k, i, got_q[i], exp_q[i]); end
      end
      checks++; if (stall_bad != 0 || stalls < 2) begin errs++; $display("FAIL bp_stall%0d unstable=%0d stalls=%0d exp unstable=0 stalls>=2", k, stall_bad, stalls); end
      @(negedge clk);
      checks++; if (bus.frame_count !== 16'(frames)) begin errs++; $display("FAIL bp_count%0d got=%0d exp=%0d", k, bus.frame_count, frames); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [B-1:0] tbl [2*NB];
    tbl = '{4'hC, 4'h3, 4'h5, 4'hA, 4'h0, 4'hF, 4'hF, 4'h0};
    exp_q.delete();
    model(16'hA53C);
    model(16'h0FF0);
    start(16'hA53C);
    bus.frame_pix = 16'h0FF0;
    collect(2 * NB, 0, NB + 1);
    frames += 2;
    checks++; if (got_q.size() != 2 * NB) begin errs++; $display("FAIL b2b_beats got=%0d exp=%0d", got_q.size(), 2 * NB); end
    for (int i = 0; i < 2 * NB && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i] || got_q[i].d !== tbl[i]) begin errs++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (cyc != 2 * NB) begin errs++; $display("FAIL b2b_gap cycles got=%0d exp=%0d", cyc, 2 * NB); end
    checks++; if (pulses != 2) begin errs++; $display("FAIL b2b_ready_pulses got=%0d exp=2", pulses); end
    @(negedge clk);
    checks++; if (bus.frame_count !== 16'(frames) || bus.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_end count=%0d valid=%b exp count=%0d valid=0", bus.frame_count, bus.out_valid, frames); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore();
    logic [W*H-1:0] f;
    f = 16'($urandom);
    exp_q.delete();
    model(f);
    start(f);
    bus.frame_pix = ~f;
    collect(NB, 0, NB - 1);
    frames++;
    for (int i = 0; i < NB && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL ignore_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pulses != 1) begin errs++; $display("FAIL ignore_ready_pulses got=%0d exp=1", pulses); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.frame_count !== 16'(frames)) begin errs++; $display("FAIL ignore_end valid=%b count=%0d exp valid=0 count=%0d", bus.out_valid, bus.frame_count, frames); end
    @(posedge clk);
    #1;
  endtask

  // one-beat frames on the second instance, held back-to-back until frame_count wraps
  task automatic test_wrap();
    logic [7:0] shown, nxt;
    shown = 8'($urandom);
    bus1.frame_pix = shown;
    bus1.frame_valid = 1;
    bus1.out_ready = 1;
    @(posedge clk);
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      if (i < 6) begin
        checks++; if (bus1.out_data !== shown) begin errs++; $display("FAIL wrap_data%0d got=%h exp=%h", i, bus1.out_data, shown); end
        checks++; if ({bus1.out_sof, bus1.out_eof, bus1.out_sol, bus1.out_eol, bus1.frame_ready} !== 5'b11111) begin errs++; $display("FAIL wrap_markers%0d got=%b exp=11111", i, {bus1.out_sof, bus1.out_eof, bus1.out_sol, bus1.out_eol, bus1.frame_ready}); end
      end
      if (i == 65535) begin
        checks++; if (bus1.frame_count !== 16'hFFFF) begin errs++; $display("FAIL wrap_full got=%h exp=ffff", bus1.frame_count); end
      end
      nxt = 8'($urandom);
      bus1.frame_pix = nxt;
      @(posedge clk);
      shown = nxt;
    end
    bus1.frame_valid = 0;
    @(negedge clk);
    checks++; if (bus1.frame_count !== 16'd0) begin errs++; $display("FAIL wrap_zero got=%h exp=0", bus1.frame_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    start(16'($urandom));
    bus.frame_valid = 0;
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.frame_count !== 16'(frames)) begin errs++; $display("FAIL mid_pre valid=%b count=%0d exp valid=1 count=%0d", bus.out_valid, bus.frame_count, frames); end
    rst_n = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_async_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.frame_count !== 16'd0) begin errs++; $display("FAIL mid_count got=%0d exp=0", bus.frame_count); end
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    checks++; if (bus.frame_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_release ready=%b valid=%b exp ready=1 valid=0", bus.frame_ready, bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_ignore();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/display_frame_streamer.md
# display_frame_streamer

Serializes the evaluated display bitmap `pix[WIDTH*HEIGHT-1:0]` from the `main` display circuit into a beat stream for the frame sink (framebuffer writer / link). Captures one full frame through a valid/ready handshake into an internal frame register, then emits it row-major, BEAT_W pixels per beat, with start/end-of-line and start/end-of-frame markers. Sits directly downstream of the display circuit's `pix` output.

## Interface

Parameters:
- WIDTH, 120, pixels per line; same value as the display circuit's `WIDTH`.
- HEIGHT, 52, lines per frame; same value as the display circuit's `HEIGHT`.
- BEAT_W, 8, pixels per output beat; WIDTH % BEAT_W must be 0, else elaboration error.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  frame_pix holds a complete frame.
- frame_ready  out  1  frame accepted on frame_valid & frame_ready.
- frame_pix  in  WIDTH*HEIGHT  bitmap; bit y*WIDTH+x is pixel (x,y), bit 0 is top-left.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts beat.
- out_data  out  BEAT_W  bit i = pixel (x0+i, y) of the current beat.
- out_sof  out  1  first beat of frame (x0=0, y=0).
- out_eof  out  1  last beat of frame.
- out_sol  out  1  first beat of a line (x0=0).
- out_eol  out  1  last beat of a line (x0=WIDTH-BEAT_W).
- frame_count  out  16  frames fully emitted, wraps 0xFFFF->0.

## Operation

- State: IDLE, STREAM. Beat position counters x0 (step BEAT_W, width clog2(WIDTH)) and y (width clog2(HEIGHT)); frame register buf[WIDTH*HEIGHT-1:0].
- Reset (async, rst_n=0): state=IDLE, x0=0, y=0, buf=0, frame_count=0; out_valid=0, all markers 0, out_data=0; frame_ready=1 once in IDLE.
- IDLE: frame_ready=1, out_valid=0. On frame_valid: buf<=frame_pix, x0<=0, y<=0, state<=STREAM.
- STREAM: out_valid=1; out_data=buf[y*WIDTH+x0 +: BEAT_W]; markers decoded from x0,y. On out_valid & out_ready (accept):
  - not eol: x0<=x0+BEAT_W.
  - eol, not eof: x0<=0, y<=y+1.
  - eof: frame_count<=frame_count+1; if frame_valid: buf<=frame_pix, x0<=0, y<=0, stay STREAM; else state<=IDLE, x0<=0, y<=0.
- frame_ready = (state==IDLE) | (state==STREAM & eof & out_ready). Combinational path out_ready->frame_ready is intentional (back-to-back frames, no bubble).
- frame_ready=0 at every other STREAM cycle; frame_pix ignored there.
- While out_valid=1 and out_ready=0: out_data and markers hold stable; no counter moves.
- Single-beat lines (WIDTH=BEAT_W): sol and eol both 1 every beat. HEIGHT=1: sof and eof on same frame's first/last beat; both 1 if WIDTH=BEAT_W.
- Reset mid-frame: partial frame discarded, frame_count not incremented, out_valid drops asynchronously.

## Timing

- Capture-to-first-beat latency: 1 cycle (frame accepted at edge N, out_valid=1 with sof from edge N).
- Throughput: 1 beat/cycle with out_ready held high; frame = WIDTH*HEIGHT/BEAT_W cycles.
- Back-to-back: next frame's sof beat appears in the cycle after previous eof accept; zero idle cycles.
- frame_count updates at the eof accept edge.
- All outputs except frame_ready are functions of registers only.

## Test plan

- Reset/idle (WIDTH=8,HEIGHT=2,BEAT_W=4): assert rst_n=0 mid-STREAM -> out_valid=0 immediately, frame_count=0, frame_ready=1 after release.
- Single frame, frame_pix=16'hA53C, out_ready=1 -> 4 beats out_data=4'hC,4'h3,4'h5,4'hA; sol/eol/sof/eof = 1010,0101 pattern: beat0 sof+sol, beat1 eol, beat2 sol, beat3 eol+eof; frame_count=1; back to IDLE.
- Backpressure: out_ready toggled 1,0,0,1,... random -> beat sequence identical to previous case, data/markers stable during stalls, no beat dropped or repeated.
- Back-to-back: frame_valid held with 16'hA53C then 16'h0FF0 -> frame_ready pulses on eof accept, 8 consecutive beats C,3,5,A,0,F,F,0 with no gap; frame_count=2.
- frame_valid during STREAM (not eof) -> frame_ready=0, frame_pix changes ignored, current frame emitted unchanged.
- Wrap: preload-run 65536 frames (or force frame_count=16'hFFFF) -> after next eof, frame_count=0.
